fft_bitrev_buffer: RTL
======================

FFT_BITREV_BUFFER -- requirements
Module: fft_bitrev_buffer

Interface
REQ-001 Parameter DATA_W, default 16, width of each real/imag component.
REQ-002 Parameter LOG2N, default 3, log2 of the frame length (N = 8).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; reset==0 at a rising edge resets the block.
REQ-005 in_valid  input  1  upstream sample present.
REQ-006 in_addr  input  LOG2N  natural-order sample index from the sample source.
REQ-007 in_real, in_imag  input  DATA_W each  complex sample, two's complement.
REQ-008 in_ready  output  1  buffer can accept a sample this cycle.
REQ-009 out_valid  output  1  output sample present.
REQ-010 out_ready  input  1  downstream butterfly stage accepts the sample.
REQ-011 out_real, out_imag  output  DATA_W each  sample at output position out_idx.
REQ-012 out_idx  output  LOG2N  output position, 0..N-1.
REQ-013 out_last  output  1  high with out_idx==N-1.
REQ-014 seq_err  output  1  one-cycle pulse on an out-of-sequence in_addr.

Function
REQ-015 Storage is two banks (ping-pong) of N complex entries; each bank has state EMPTY, FILLING, FULL or DRAINING.
REQ-016 An input transfer occurs when in_valid && in_ready; the sample is written to write-bank entry bitrev(in_addr).
REQ-017 A write counter wr_cnt tracks the expected in_addr; a transfer with in_addr==wr_cnt is stored and increments wr_cnt (wrapping N-1 -> 0).
REQ-018 On a transfer with in_addr!=wr_cnt, seq_err pulses the next cycle and wr_cnt restarts at 0.
REQ-019 If that mismatched in_addr is 0, the sample is stored as entry 0 and wr_cnt becomes 1; otherwise the sample is dropped.
REQ-020 Accepting index N-1 marks the write bank FULL and moves the write pointer to the other bank.
REQ-021 in_ready is high iff the current write bank is EMPTY or FILLING.
REQ-022 The read side takes the oldest FULL bank, marks it DRAINING, and presents entries 0..N-1 in order; out_real/out_imag at out_idx=k equal the input sample with in_addr=bitrev(k).
REQ-023 out_valid first rises the cycle after the Nth write of a frame when the read side is idle (latency 1).
REQ-024 An output transfer occurs when out_valid && out_ready; out_idx advances by 1. The transfer with out_last returns the bank to EMPTY.
REQ-025 out_valid and the data are stable while out_ready is low.
REQ-026 With back-to-back FULL banks, the first output of the next bank follows the out_last transfer with no idle cycle.
REQ-027 When a bank frees (out_last) in the same cycle the write side is stalled on it, in_ready rises the following cycle.
REQ-028 When a frame completes and the other bank finishes draining in the same cycle, both transitions take effect; no sample is lost or duplicated.

Reset
REQ-029 On reset==0, both banks are EMPTY, wr_cnt=0, the write and read pointers select bank 0, and the read index is 0.
REQ-030 On reset, outputs are out_valid=0, out_idx=0, out_last=0, seq_err=0, out_real=0, out_imag=0, and in_ready=1 from the first cycle after release.
REQ-031 A reset mid-frame discards all buffered data; bank contents need not be cleared.

Structure
REQ-032 A shared FFT package holds LOG2N/N and DATA_W defaults, the bank-state enumeration, and the bit-reverse function.
REQ-033 The only sub-module is fft_bank_ram: a 2*N x 2*DATA_W register array with one write port and one read port, read asynchronously into the output registers.

Verification
REQ-034 Eight samples with in_addr 0..7, real=addr*100 and imag=-addr, out_ready=1 -> out_idx 0..7 carry real 0,400,200,600,100,500,300,700; out_last is high at idx 7.
REQ-035 Two frames streamed back-to-back with out_ready=0 -> in_ready drops after 16 accepts; raising out_ready then drains 16 outputs with no gap.
REQ-036 in_addr sequence 0,1,2,5 -> seq_err pulses once and the 5 is dropped; the next sequence 0..7 produces a correct frame.
REQ-037 out_ready toggled every cycle during drain -> the data at each index is held until accepted and all 8 values are correct.
REQ-038 reset=0 asserted after 4 writes -> all outputs return to their reset values; a following full frame outputs correctly with no stale data.
REQ-039 out_last accepted in the same cycle the other bank's 8th write is accepted -> that bank's out_idx 0 output is valid the next cycle and in_ready=1.

Source files
------------

// File: rtl/fft_bitrev_buffer_pkg.sv
// Shared FFT definitions: default sizes, bank state encoding and index bit reversal.
package fft_bitrev_buffer_pkg;

    localparam int unsigned FFT_LOG2N  = 3;
    localparam int unsigned FFT_N      = 1 << FFT_LOG2N;
    localparam int unsigned FFT_DATA_W = 16;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_e;

    // Reverse the low 'width' bits of value; upper bits return as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] value, input int unsigned width);
        logic [31:0] rev;
        rev = '0;
        for (int unsigned i = 0; i < width; i++) begin
            rev[i] = value[width - 1 - i];
        end
        return rev;
    endfunction

endpackage

// File: rtl/fft_bank_ram.sv
// Two-bank complex sample store: one synchronous write port, one asynchronous read port.
module fft_bank_ram
    import fft_bitrev_buffer_pkg::*;
#(
    parameter int unsigned DATA_W = FFT_DATA_W,
    parameter int unsigned LOG2N  = FFT_LOG2N
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [LOG2N:0]        waddr,
    input  logic [2*DATA_W-1:0]   wdata,
    input  logic [LOG2N:0]        raddr,
    output logic [2*DATA_W-1:0]   rdata
);

    localparam int unsigned DEPTH = 2 << LOG2N;

    logic [2*DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fft_bitrev_buffer.sv
// Ping-pong bit-reversal reorder buffer: natural-order frames in, bit-reversed order out.
module fft_bitrev_buffer
    import fft_bitrev_buffer_pkg::*;
#(
    parameter int unsigned DATA_W = FFT_DATA_W,
    parameter int unsigned LOG2N  = FFT_LOG2N
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [LOG2N-1:0]  in_addr,
    input  logic [DATA_W-1:0] in_real,
    input  logic [DATA_W-1:0] in_imag,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_real,
    output logic [DATA_W-1:0] out_imag,
    output logic [LOG2N-1:0]  out_idx,
    output logic              out_last,
    output logic              seq_err
);

    localparam int unsigned N = (LOG2N == FFT_LOG2N) ? FFT_N : (1 << LOG2N);
    localparam logic [LOG2N-1:0] IDX_LAST = LOG2N'(N - 1);

    bank_state_e         bank_st_q [2];
    bank_state_e         bank_st_d [2];
    logic                wr_bank_q, wr_bank_d;
    logic                rd_bank_q, rd_bank_d;
    logic [LOG2N-1:0]    wr_cnt_q, wr_cnt_d;
    logic [LOG2N-1:0]    rd_idx_q, rd_idx_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic                seq_err_q, seq_err_d;
    logic                in_ready_q, in_ready_d;
    logic [DATA_W-1:0]   out_real_q, out_real_d;
    logic [DATA_W-1:0]   out_imag_q, out_imag_d;

    logic                in_xfer_c, out_xfer_c, addr_match_c, ram_we_c, load_c;
    logic [LOG2N:0]      ram_waddr_c, ram_raddr_c;
    logic [2*DATA_W-1:0] ram_rdata_c;

    assign ram_waddr_c = {wr_bank_q, LOG2N'(bitrev(32'(in_addr), LOG2N))};
    assign ram_raddr_c = {rd_bank_d, rd_idx_d};

    fft_bank_ram #(
        .DATA_W (DATA_W),
        .LOG2N  (LOG2N)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_c),
        .waddr (ram_waddr_c),
        .wdata ({in_real, in_imag}),
        .raddr (ram_raddr_c),
        .rdata (ram_rdata_c)
    );

    // Write-side sequencing first, then read side; they never claim the same bank in one cycle.
    always_comb begin
        bank_st_d    = bank_st_q;
        wr_bank_d    = wr_bank_q;
        rd_bank_d    = rd_bank_q;
        wr_cnt_d     = wr_cnt_q;
        rd_idx_d     = rd_idx_q;
        out_valid_d  = out_valid_q;
        seq_err_d    = 1'b0;
        ram_we_c     = 1'b0;
        load_c       = 1'b0;

        in_xfer_c    = in_valid && in_ready_q;
        out_xfer_c   = out_valid_q && out_ready;
        addr_match_c = (in_addr == wr_cnt_q);

        if (in_xfer_c) begin
            seq_err_d = !addr_match_c;
            if (addr_match_c) begin
                wr_cnt_d = wr_cnt_q + LOG2N'(1);
            end else if (in_addr == '0) begin
                wr_cnt_d = LOG2N'(1);
            end else begin
                wr_cnt_d = '0;
            end
            if (addr_match_c || (in_addr == '0)) begin
                ram_we_c             = 1'b1;
                bank_st_d[wr_bank_q] = BANK_FILLING;
                if (addr_match_c && (in_addr == IDX_LAST)) begin
                    bank_st_d[wr_bank_q] = BANK_FULL;
                    wr_bank_d            = ~wr_bank_q;
                end
            end
        end

        if (out_xfer_c) begin
            if (out_last_q) begin
                bank_st_d[rd_bank_q] = BANK_EMPTY;
                rd_bank_d            = ~rd_bank_q;
                rd_idx_d             = '0;
                out_valid_d          = 1'b0;
                if (bank_st_d[~rd_bank_q] == BANK_FULL) begin
                    bank_st_d[~rd_bank_q] = BANK_DRAINING;
                    out_valid_d           = 1'b1;
                    load_c                = 1'b1;
                end
            end else begin
                rd_idx_d = rd_idx_q + LOG2N'(1);
                load_c   = 1'b1;
            end
        end else if (!out_valid_q && (bank_st_d[rd_bank_q] == BANK_FULL)) begin
            bank_st_d[rd_bank_q] = BANK_DRAINING;
            rd_idx_d             = '0;
            out_valid_d          = 1'b1;
            load_c               = 1'b1;
        end

        out_last_d = out_valid_d && (rd_idx_d == IDX_LAST);
        in_ready_d = (bank_st_d[wr_bank_d] == BANK_EMPTY) ||
                     (bank_st_d[wr_bank_d] == BANK_FILLING);
    end

    // Output data only changes when a new entry is presented.
    always_comb begin
        out_real_d = out_real_q;
        out_imag_d = out_imag_q;
        if (load_c) begin
            out_real_d = ram_rdata_c[2*DATA_W-1:DATA_W];
            out_imag_d = ram_rdata_c[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bank_st_q[0] <= BANK_EMPTY;
            bank_st_q[1] <= BANK_EMPTY;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            wr_cnt_q     <= '0;
            rd_idx_q     <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            seq_err_q    <= 1'b0;
            in_ready_q   <= 1'b1;
            out_real_q   <= '0;
            out_imag_q   <= '0;
        end else begin
            bank_st_q    <= bank_st_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_idx_q     <= rd_idx_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            seq_err_q    <= seq_err_d;
            in_ready_q   <= in_ready_d;
            out_real_q   <= out_real_d;
            out_imag_q   <= out_imag_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_real  = out_real_q;
    assign out_imag  = out_imag_q;
    assign out_idx   = rd_idx_q;
    assign out_last  = out_last_q;
    assign seq_err   = seq_err_q;

endmodule
